// File: rtl/approx_arith_pkg.sv
// Shared types and widths for the approximate arithmetic lanes.
// Purely declarative: no logic, no latency, no flow control.
// Operand pairs travel as one packed add_op_t so muxing and staging stay one bus.
package approx_arith_pkg;

    localparam int ADD_W = 16;
    localparam int SUM_W = 17;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
    } add_op_t;

endpackage

// File: rtl/add16u_0P5.sv
// Approximate 16-bit unsigned adder: exact upper 12 bits, guessed low nibble.
// Purely combinational, zero latency, no flow control.
// Error against the exact sum never exceeds 9.
module add16u_0P5 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [16:0] O
);

    logic [12:0] hi_sum;
    logic        unused_low_bits;

    // Bit 3 of each operand stands in for the whole low-nibble carry;
    // O[3] picks the midpoint of the remaining range so the error stays centred.
    assign hi_sum = {1'b0, A[15:4]} + {1'b0, B[15:4]} + {12'd0, A[3] | B[3]};
    assign O      = {hi_sum, ~(A[3] ^ B[3]), 2'b00, A[13] & B[13]};

    assign unused_low_bits = ^{A[2:0], B[2:0]};

endmodule

// File: rtl/approx_rr_arbiter.sv
// Round-robin grant among NREQ requesters, search starts at the pointer.
// Grant is combinational; pointer moves one edge after an enabled grant.
// en=0 freezes the pointer so a stalled consumer never loses its turn order.
module approx_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign gnt = gnt_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (en && gnt_vld) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/approx_add_arbiter.sv
// Shares one approximate adder among NREQ lanes with round-robin arbitration.
// Two register stages: operand capture, then tagged result (transfer at k -> valid after k+1).
// res_ready low holds the result stage; a full operand stage then drops req_ready to zero.
module approx_add_arbiter
    import approx_arith_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [SUM_W-1:0]      res_sum,
    output logic [IDW-1:0]        res_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_cnt
);

    logic            adv;
    logic            acc;
    logic            xfer;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_vld;
    add_op_t         op_sel;
    logic [SUM_W-1:0] add_o;

    logic            s1_valid_q, s1_valid_d;
    add_op_t         s1_op_q,    s1_op_d;
    logic [IDW-1:0]  s1_id_q,    s1_id_d;
    logic            res_valid_q, res_valid_d;
    logic [SUM_W-1:0] res_sum_q,  res_sum_d;
    logic [IDW-1:0]  res_id_q,   res_id_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    assign adv = !res_valid_q || res_ready;
    // rst_n gates acceptance so req_ready reads zero while reset is asserted.
    assign acc  = (!s1_valid_q || adv) && !flush && rst_n;
    assign xfer = acc && gnt_vld;

    approx_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (acc),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = acc ? gnt : '0;

    always_comb begin
        op_sel.a = req_a[int'(gnt_id)*ADD_W +: ADD_W];
        op_sel.b = req_b[int'(gnt_id)*ADD_W +: ADD_W];
    end

    add16u_0P5 u_add (
        .A (s1_op_q.a),
        .B (s1_op_q.b),
        .O (add_o)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_id_d     = s1_id_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        done_cnt_d  = done_cnt_q;

        // A result leaving in the flush cycle was already delivered, so it counts.
        if (res_valid_q && res_ready) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            s1_valid_d  = 1'b0;
            res_valid_d = 1'b0;
        end else begin
            if (adv) begin
                res_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    res_sum_d = add_o;
                    res_id_d  = s1_id_q;
                end
            end
            if (xfer) begin
                s1_valid_d = 1'b1;
                s1_op_d    = op_sel;
                s1_id_d    = gnt_id;
            end else if (adv) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
            done_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_id_q     <= s1_id_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign busy      = s1_valid_q || res_valid_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Bench for approx_add_arbiter: directed scenarios plus randomized traffic,
// checked against a cycle-level model and an in-order result scoreboard.
module tb_approx_add_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_a = '0;
    logic [N*16-1:0] req_b = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [16:0]     res_sum;
    logic [IDW-1:0]  res_id;
    logic            busy;
    logic [15:0]     done_cnt;

    always #5 clk = ~clk;

    approx_add_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    typedef struct {
        int id;
        int sum;
        int exact;
    } exp_t;

    exp_t        sb[$];
    int          gnt_log[$];
    int          res_log[$];
    int          hs_cnt;
    int          checks = 0;
    int          errors = 0;

    bit          pend[N];
    logic [15:0] pa[N];
    logic [15:0] pb[N];
    int          gen_mode = 0;

    int          m_ptr;
    bit          m_s1_v;
    int          m_s1_sum;
    int          m_s1_id;
    bit          m_r_v;
    int          m_r_sum;
    int          m_r_id;
    logic [15:0] m_done;

    // Upper 12 bits summed exactly with bit 3 as carry guess; low nibble is 8 or 0 plus A13&B13.
    function automatic int ref_add(int a, int b);
        int hi;
        int v;
        hi = (a / 16) + (b / 16) + ((((a / 8) % 2) + ((b / 8) % 2)) > 0 ? 1 : 0);
        v  = hi * 16;
        if (((a / 8) % 2) == ((b / 8) % 2)) v = v + 8;
        if (((a / 8192) % 2) == 1 && ((b / 8192) % 2) == 1) v = v + 1;
        return v;
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic new_op(input int i);
        pend[i] = 1'b1;
        pa[i]   = 16'($urandom_range(0, 65535));
        pb[i]   = 16'($urandom_range(0, 65535));
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && gen_mode == 1) new_op(i);
            if (!pend[i] && gen_mode == 2 && $urandom_range(0, 1) == 1) new_op(i);
            req_valid[i]        = pend[i];
            req_a[i*16 +: 16]   = pa[i];
            req_b[i*16 +: 16]   = pb[i];
        end
    endtask

    // One clock cycle: drive at negedge, check at +1, update model at posedge.
    task automatic step();
        int   g;
        bit   adv;
        bit   acc;
        int   exp_rdy;
        int   d;
        int   g_sum;
        exp_t e;
        drive_inputs();
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        adv     = !m_r_v || res_ready;
        acc     = (!m_s1_v || adv) && !flush;
        exp_rdy = (acc && g >= 0) ? (1 << g) : 0;
        g_sum   = (g >= 0) ? ref_add(int'(pa[g]), int'(pb[g])) : 0;
        chk("req_ready", int'(req_ready), exp_rdy);
        chk("res_valid", int'(res_valid), int'(m_r_v));
        chk("res_sum",   int'(res_sum),   m_r_sum);
        chk("res_id",    int'(res_id),    m_r_id);
        chk("busy",      int'(busy),      int'(m_s1_v || m_r_v));
        chk("done_cnt",  int'(done_cnt),  int'(m_done));

        if (res_valid && res_ready) begin
            hs_cnt++;
            res_log.push_back(int'(res_id));
            if (sb.size() == 0) begin
                chk("sb_spurious_id", int'(res_id), -1);
            end else begin
                e = sb.pop_front();
                chk("sb_id",  int'(res_id),  e.id);
                chk("sb_sum", int'(res_sum), e.sum);
                d = int'(res_sum) - e.exact;
                if (d < 0) d = -d;
                chk("err_bound", (d <= 9) ? 1 : 0, 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                gnt_log.push_back(i);
                sb.push_back('{i, ref_add(int'(pa[i]), int'(pb[i])), int'(pa[i]) + int'(pb[i])});
                pend[i] = 1'b0;
            end
        end

        @(posedge clk);
        if (m_r_v && res_ready) m_done = m_done + 16'd1;
        if (flush) begin
            m_r_v  = 1'b0;
            m_s1_v = 1'b0;
            sb.delete();
        end else begin
            if (adv) begin
                if (m_s1_v) begin
                    m_r_v   = 1'b1;
                    m_r_sum = m_s1_sum;
                    m_r_id  = m_s1_id;
                end else begin
                    m_r_v = 1'b0;
                end
            end
            if (acc && g >= 0) begin
                m_s1_v   = 1'b1;
                m_s1_sum = g_sum;
                m_s1_id  = g;
                m_ptr    = (g + 1) % N;
            end else if (adv) begin
                m_s1_v = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the immediate effect, releases on the next negedge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_sum",   int'(res_sum),   0);
        chk("rst_res_id",    int'(res_id),    0);
        chk("rst_done_cnt",  int'(done_cnt),  0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_s1_v   = 1'b0;
        m_s1_sum = 0;
        m_s1_id  = 0;
        m_r_v    = 1'b0;
        m_r_sum  = 0;
        m_r_id   = 0;
        m_done   = '0;
        hs_cnt   = 0;
        sb.delete();
        gnt_log.delete();
        res_log.delete();
    endtask

    initial begin
        int s0;
        int last_g;
        int hold_sum;
        int hold_id;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pb[i]   = '0;
        end
        @(negedge clk);
        req_valid = 4'b1111;
        do_reset();

        // Single requester, basic sum and latency
        res_ready = 1'b1;
        pend[0] = 1'b1; pa[0] = 16'h0010; pb[0] = 16'h0020;
        step();
        chk("t1_gnt_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
        step();
        chk("t1_res_valid", int'(res_valid), 1);
        chk("t1_res_sum",   int'(res_sum),   'h38);
        chk("t1_res_id",    int'(res_id),    0);
        step();
        chk("t1_done_cnt",  int'(done_cnt),  1);

        // Carry out of the top bit
        pend[0] = 1'b1; pa[0] = 16'hFFFF; pb[0] = 16'h0001;
        step();
        step();
        chk("t2_res_sum", int'(res_sum), 'h10000);
        chk("t2_res_id",  int'(res_id),  0);
        step();

        // All requesters continuously valid from reset: strict rotation
        do_reset();
        gen_mode  = 1;
        res_ready = 1'b1;
        for (int c = 0; c < 40 && hs_cnt < 8; c++) step();
        chk("rot_results", hs_cnt, 8);
        chk("rot_done_cnt", int'(done_cnt), 8);
        for (int i = 0; i < 8; i++) begin
            chk("rot_gnt_order", (gnt_log.size() > i) ? gnt_log[i] : -1, i % N);
            chk("rot_res_order", (res_log.size() > i) ? res_log[i] : -1, i % N);
        end

        // Stall from an empty pipeline: two accepts, then frozen outputs
        flush = 1'b1;
        step();
        flush = 1'b0;
        s0 = gnt_log.size();
        res_ready = 1'b0;
        hold_sum = 0;
        hold_id  = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 1) begin
                hold_sum = int'(res_sum);
                hold_id  = int'(res_id);
            end else if (c > 1) begin
                chk("stall_sum_hold", int'(res_sum), hold_sum);
                chk("stall_id_hold",  int'(res_id),  hold_id);
            end
        end
        chk("stall_accepts", gnt_log.size() - s0, 2);
        res_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();

        // Flush with both stages full keeps the pointer
        res_ready = 1'b0;
        step();
        step();
        last_g = gnt_log[$];
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_res_valid", int'(res_valid), 0);
        chk("flush_busy",      int'(busy),      0);
        res_ready = 1'b1;
        s0 = gnt_log.size();
        step();
        chk("flush_one_grant", gnt_log.size() - s0, 1);
        chk("flush_next_gnt",  gnt_log[$], (last_g + 1) % N);

        // Asynchronous reset mid-stream
        for (int c = 0; c < 3; c++) step();
        do_reset();
        step();
        chk("arst_one_grant",  gnt_log.size(), 1);
        chk("arst_first_gnt",  (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

        // Randomized traffic with backpressure and occasional flush
        gen_mode = 2;
        for (int c = 0; c < 400; c++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step();
        end
        flush     = 1'b0;
        gen_mode  = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 12; c++) step();
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
